// File: rtl/alien_draw_sequencer_pkg.sv
// Game-wide constants shared by the alien, player and bullet draw sequencers:
// grid geometry, sprite pitch, screen size and the sequencer state encoding.
package alien_draw_sequencer_pkg;

   // Sequencer state encoding, also exported on the debug state port.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SCAN     = 3'd1,
      ST_ISSUE    = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4
   } seq_state_t;

   localparam int STATE_W = 3;

   // Alien grid geometry and sprite pitch in pixels.
   localparam int GRID_COLS       = 8;
   localparam int GRID_ROWS       = 4;
   localparam int ALIEN_X_SPACING = 8;
   localparam int ALIEN_Y_SPACING = 6;

   // Visible screen size; coordinate widths are derived from these.
   localparam int SCREEN_W = 256;
   localparam int SCREEN_H = 128;

   // Counter width able to hold 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alien_draw_sequencer_grid_pos_counter.sv
// Column/row position counter for a row-major grid walk.
// clear wins over advance; col wraps to 0 and bumps row; last marks the final cell.
module grid_pos_counter
   import alien_draw_sequencer_pkg::*;
#(
   parameter int COLS  = GRID_COLS,
   parameter int ROWS  = GRID_ROWS,
   parameter int COL_W = cnt_width(GRID_COLS),
   parameter int ROW_W = cnt_width(GRID_ROWS),
   parameter int IDX_W = cnt_width(GRID_COLS * GRID_ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

   // Position register: clear to origin, or step one cell in row-major order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign idx  = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
   assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/alien_draw_sequencer.sv
// Frame sequencer for the alien pixel drawer. Walks the alien grid in
// row-major order, skips dead aliens, and for each live one presents the
// sprite base pixel with a one-cycle draw_enable pulse, then waits for the
// drawer to report completion before moving on.
//
// Handshake: draw_enable is a single-cycle request that is never held;
// x_pixel/y_pixel are valid from that cycle until continue_draw is seen.
// continue_draw is only sampled in the cycles after the request (WAIT_ACK);
// a level held high during the request cycle or while scanning is ignored,
// so one request is completed by exactly one sampled continue_draw.
module alien_draw_sequencer
   import alien_draw_sequencer_pkg::*;
#(
   parameter int COLS      = GRID_COLS,
   parameter int ROWS      = GRID_ROWS,
   parameter int X_SPACING = ALIEN_X_SPACING,
   parameter int Y_SPACING = ALIEN_Y_SPACING,
   parameter int X_W       = $clog2(SCREEN_W),
   parameter int Y_W       = $clog2(SCREEN_H)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [X_W-1:0]       origin_x,
   input  logic [Y_W-1:0]       origin_y,
   input  logic [ROWS*COLS-1:0] alive,
   input  logic                 continue_draw,
   output logic                 draw_enable,
   output logic [X_W-1:0]       x_pixel,
   output logic [Y_W-1:0]       y_pixel,
   output logic                 busy,
   output logic                 done,
   output logic [STATE_W-1:0]   state_dbg
);

   localparam int N     = ROWS * COLS;
   localparam int COL_W = cnt_width(COLS);
   localparam int ROW_W = cnt_width(ROWS);
   localparam int IDX_W = cnt_width(N);

   seq_state_t       state;
   seq_state_t       state_next;

   logic [X_W-1:0]   origin_x_l;
   logic [Y_W-1:0]   origin_y_l;
   logic [N-1:0]     alive_l;

   logic             cnt_clear;
   logic             cnt_advance;
   logic             load_xy;
   logic             accept_start;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [IDX_W-1:0] idx;
   logic             last;

   logic [X_W-1:0]   x_next;
   logic [Y_W-1:0]   y_next;

   grid_pos_counter #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .COL_W (COL_W),
      .ROW_W (ROW_W),
      .IDX_W (IDX_W)
   ) u_pos (
      .clk     (clk),
      .reset   (reset),
      .clear   (cnt_clear),
      .advance (cnt_advance),
      .col     (col),
      .row     (row),
      .idx     (idx),
      .last    (last)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and counter/coordinate control strobes.
   always_comb begin
      state_next   = state;
      cnt_clear    = 1'b0;
      cnt_advance  = 1'b0;
      load_xy      = 1'b0;
      accept_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               cnt_clear    = 1'b1;
               state_next   = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (alive_l[idx]) begin
               load_xy    = 1'b1;
               state_next = ST_ISSUE;
            end else if (last) begin
               state_next = ST_DONE;
            end else begin
               cnt_advance = 1'b1;
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (continue_draw) begin
               if (last) begin
                  state_next = ST_DONE;
               end else begin
                  cnt_advance = 1'b1;
                  state_next  = ST_SCAN;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Sprite base pixel for the alien under the counter; wraps modulo 2^W.
   assign x_next = origin_x_l + X_W'(col) * X_W'(X_SPACING);
   assign y_next = origin_y_l + Y_W'(row) * Y_W'(Y_SPACING);

   // Frame parameters are frozen at start so mid-frame input changes are invisible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         origin_x_l <= '0;
         origin_y_l <= '0;
         alive_l    <= '0;
      end else if (accept_start) begin
         origin_x_l <= origin_x;
         origin_y_l <= origin_y;
         alive_l    <= alive;
      end
   end

   // Coordinates are captured on entry to ISSUE and held through WAIT_ACK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_pixel <= '0;
         y_pixel <= '0;
      end else if (load_xy) begin
         x_pixel <= x_next;
         y_pixel <= y_next;
      end
   end

   assign draw_enable = (state == ST_ISSUE);
   assign done        = (state == ST_DONE);
   assign busy        = (state != ST_IDLE);
   assign state_dbg   = state;

endmodule

// File: tb/tb_alien_draw_sequencer.sv
// Directed bench for alien_draw_sequencer. A frame-level model predicts, from
// the latched mask/origin and the observed acknowledge timing, the exact cycle
// of every draw_enable and done pulse and the pixel each alien must be drawn at.
module tb_alien_draw_sequencer;

   localparam int N_COLS  = 8;
   localparam int N_ALIEN = 32;
   localparam int XS      = 8;
   localparam int YS      = 6;
   localparam int ACK_DLY = 5;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  origin_x;
   logic [6:0]  origin_y;
   logic [31:0] alive;
   logic        continue_draw;
   logic        draw_enable;
   logic [7:0]  x_pixel;
   logic [6:0]  y_pixel;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   int n_tests;
   int n_fail;
   int cyc;
   int ack_mode;   // 0: pulse ACK_DLY cycles after draw, 1: hold high, 2: never
   int ack_cnt;

   // Frame model state
   bit          m_active;
   bit          m_wait_ack;
   bit          m_evt_draw;
   int          m_evt_cyc;
   int          m_evt_idx;
   int          m_start_cyc;
   logic [7:0]  m_ox;
   logic [6:0]  m_oy;
   logic [31:0] m_alive;
   logic [7:0]  m_x;
   logic [6:0]  m_y;

   // Observed activity
   int          dut_draws;
   int          dut_dones;
   int          done_cyc;
   logic [7:0]  lx[$];
   logic [6:0]  ly[$];

   alien_draw_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .origin_x      (origin_x),
      .origin_y      (origin_y),
      .alive         (alive),
      .continue_draw (continue_draw),
      .draw_enable   (draw_enable),
      .x_pixel       (x_pixel),
      .y_pixel       (y_pixel),
      .busy          (busy),
      .done          (done),
      .state_dbg     (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Predict the next event: the scan resumes at alien from_idx in cycle from_c,
   // each examined dead alien costs one cycle, a live one is requested the cycle
   // after it is examined, and done follows the scan of the last alien.
   task automatic plan_from(input int from_c, input int from_idx);
      int j;
      j = from_idx;
      while (j < N_ALIEN && !m_alive[j]) j++;
      if (j < N_ALIEN) begin
         m_evt_draw = 1'b1;
         m_evt_idx  = j;
         m_evt_cyc  = from_c + (j - from_idx) + 1;
      end else begin
         m_evt_draw = 1'b0;
         m_evt_cyc  = from_c + (N_ALIEN - from_idx);
      end
   endtask

   // ---------------- compare process (every cycle, mid-cycle) ----------------
   always @(negedge clk) begin
      bit exp_de;
      bit exp_done;
      if (reset) begin
         check("rst_draw_enable", {31'd0, draw_enable}, 32'd0);
         check("rst_busy",        {31'd0, busy},        32'd0);
         check("rst_done",        {31'd0, done},        32'd0);
         check("rst_x_pixel",     {24'd0, x_pixel},     32'd0);
         check("rst_y_pixel",     {25'd0, y_pixel},     32'd0);
         m_active   = 1'b0;
         m_wait_ack = 1'b0;
      end else begin
         exp_de   = m_active && !m_wait_ack &&  m_evt_draw && (cyc == m_evt_cyc);
         exp_done = m_active && !m_wait_ack && !m_evt_draw && (cyc == m_evt_cyc);
         check("draw_enable", {31'd0, draw_enable}, {31'd0, exp_de});
         check("done",        {31'd0, done},        {31'd0, exp_done});
         check("busy",        {31'd0, busy},        {31'd0, m_active});
         if (draw_enable) begin
            dut_draws++;
            lx.push_back(x_pixel);
            ly.push_back(y_pixel);
         end
         if (done) begin
            dut_dones++;
            done_cyc = cyc;
         end
         if (m_wait_ack) begin
            check("hold_x_pixel", {24'd0, x_pixel}, {24'd0, m_x});
            check("hold_y_pixel", {25'd0, y_pixel}, {25'd0, m_y});
         end
         if (exp_de) begin
            m_x = 8'(int'(m_ox) + (m_evt_idx % N_COLS) * XS);
            m_y = 7'(int'(m_oy) + (m_evt_idx / N_COLS) * YS);
            check("x_pixel", {24'd0, x_pixel}, {24'd0, m_x});
            check("y_pixel", {25'd0, y_pixel}, {25'd0, m_y});
            m_wait_ack = 1'b1;
         end else if (m_wait_ack && continue_draw) begin
            m_wait_ack = 1'b0;
            if (m_evt_idx == N_ALIEN - 1) begin
               m_evt_draw = 1'b0;
               m_evt_cyc  = cyc + 1;
            end else begin
               plan_from(cyc + 1, m_evt_idx + 1);
            end
         end
         if (exp_done) begin
            m_active = 1'b0;
         end else if (!m_active && start) begin
            m_active    = 1'b1;
            m_wait_ack  = 1'b0;
            m_ox        = origin_x;
            m_oy        = origin_y;
            m_alive     = alive;
            m_start_cyc = cyc;
            plan_from(cyc + 1, 0);
         end
      end
   end

   // ---------------- drawer responder ----------------
   initial begin
      continue_draw = 1'b0;
      ack_cnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_mode == 1) begin
            continue_draw = 1'b1;
            ack_cnt       = 0;
         end else if (ack_mode == 0 && draw_enable) begin
            ack_cnt       = ACK_DLY;
            continue_draw = 1'b0;
         end else if (ack_cnt > 0) begin
            ack_cnt--;
            continue_draw = (ack_cnt == 0);
         end else begin
            continue_draw = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [7:0] ox, input logic [6:0] oy, input logic [31:0] mask);
      @(posedge clk);
      #1;
      origin_x = ox;
      origin_y = oy;
      alive    = mask;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
   endtask

   task automatic wait_frame_done(input int budget, input string name);
      int  d0;
      bit  seen;
      d0   = dut_dones;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         if (dut_dones != d0) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd1);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_draw(input int budget, input string name);
      int  d0;
      bit  seen;
      d0   = dut_draws;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         if (dut_draws != d0) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int draws0;
      int dones0;
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      ack_mode = 0;
      reset    = 1'b1;
      start    = 1'b0;
      origin_x = '0;
      origin_y = '0;
      alive    = '0;
      dut_draws = 0;
      dut_dones = 0;
      done_cyc  = 0;
      m_active  = 1'b0;
      m_wait_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      // All alive, origin (10,5), ack 5 cycles after each request. A second start
      // and changed origin/mask mid-frame must not disturb the frame.
      base   = lx.size();
      draws0 = dut_draws;
      dones0 = dut_dones;
      do_start(8'd10, 7'd5, 32'hFFFF_FFFF);
      repeat (20) @(posedge clk);
      #1;
      origin_x = 8'd99;
      origin_y = 7'd77;
      alive    = 32'h0000_0000;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_frame_done(600, "all_alive_timeout");
      check("all_alive_draws", dut_draws - draws0, 32);
      check("all_alive_dones", dut_dones - dones0, 1);
      if (lx.size() >= base + 32) begin
         check("first_x", {24'd0, lx[base]},      10);
         check("first_y", {25'd0, ly[base]},      5);
         check("ninth_x", {24'd0, lx[base + 8]},  10);
         check("ninth_y", {25'd0, ly[base + 8]},  11);
         check("last_x",  {24'd0, lx[base + 31]}, 66);
         check("last_y",  {25'd0, ly[base + 31]}, 23);
      end

      // Single live alien at index 0.
      base   = lx.size();
      draws0 = dut_draws;
      do_start(8'd10, 7'd5, 32'h0000_0001);
      wait_frame_done(100, "single_timeout");
      check("single_draws", dut_draws - draws0, 1);
      if (lx.size() > base) begin
         check("single_x", {24'd0, lx[base]}, 10);
         check("single_y", {25'd0, ly[base]}, 5);
      end

      // Nothing alive: a pure scan, done 33 cycles after the start cycle.
      draws0 = dut_draws;
      do_start(8'd10, 7'd5, 32'h0000_0000);
      wait_frame_done(100, "dead_timeout");
      check("dead_draws", dut_draws - draws0, 0);
      check("dead_done_latency", done_cyc - m_start_cyc, 33);

      // X coordinate wraps: 250 + 1*8 = 258 -> 2.
      base = lx.size();
      do_start(8'd250, 7'd5, 32'h0000_0002);
      wait_frame_done(100, "wrap_timeout");
      if (lx.size() > base) begin
         check("wrap_x", {24'd0, lx[base]}, 2);
         check("wrap_y", {25'd0, ly[base]}, 5);
      end else begin
         check("wrap_draw_count", lx.size() - base, 1);
      end

      // continue_draw held high through every state: one advance per request.
      ack_mode = 1;
      base   = lx.size();
      draws0 = dut_draws;
      do_start(8'd20, 7'd30, 32'h8000_0105);
      wait_frame_done(200, "hold_timeout");
      check("hold_draws", dut_draws - draws0, 4);
      if (lx.size() >= base + 4) begin
         check("hold_third_x", {24'd0, lx[base + 2]}, 20);
         check("hold_third_y", {25'd0, ly[base + 2]}, 36);
         check("hold_last_x",  {24'd0, lx[base + 3]}, 76);
         check("hold_last_y",  {25'd0, ly[base + 3]}, 48);
      end
      ack_mode = 2;
      repeat (3) @(posedge clk);

      // Reset while waiting for the drawer.
      do_start(8'd10, 7'd5, 32'hFFFF_FFFF);
      wait_draw(50, "pre_reset_draw_timeout");
      @(posedge clk);
      #1;
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_draw_enable", {31'd0, draw_enable}, 32'd0);
      check("async_rst_busy",        {31'd0, busy},        32'd0);
      check("async_rst_x_pixel",     {24'd0, x_pixel},     32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      ack_mode = 0;
      draws0 = dut_draws;
      repeat (15) @(posedge clk);
      check("post_reset_no_draw", dut_draws - draws0, 0);

      // A new start after reset works normally.
      base = lx.size();
      do_start(8'd40, 7'd2, 32'h0000_0100);
      wait_frame_done(100, "post_reset_timeout");
      check("post_reset_draws", dut_draws - draws0, 1);
      if (lx.size() > base) begin
         check("post_reset_x", {24'd0, lx[base]}, 40);
         check("post_reset_y", {25'd0, ly[base]}, 8);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
